hazard_ctrl_mc: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core; sits beside the datapath and drives every stall, flush and forward select.
- Successor to the combinational hazard unit, with the register-address width and the number of multi-cycle execution channels (div, mul, …) parametrised.
- Adds a registered per-channel start/wait/done handshake, so each multi-cycle unit gets a one-cycle start pulse and is never restarted for the same instruction.
- Adds an exception flush that aborts in-flight multi-cycle operations.

---
 rtl/hazard_ctrl_mc_if.sv | 24 ++
 rtl/hazard_ctrl_mc.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_mc_if.sv
// Handshake bundle between the hazard controller and its multi-cycle execution channels.
// The master side is the controller: it issues start/cancel and observes request/ready.
interface hazard_ctrl_mc_if #(
    parameter int unsigned NUM_MC = 2
);
    logic [NUM_MC-1:0] mc_reqE;
    logic [NUM_MC-1:0] mc_ready;
    logic [NUM_MC-1:0] mc_start;
    logic [NUM_MC-1:0] mc_cancel;

    modport master (
        input  mc_reqE,
        input  mc_ready,
        output mc_start,
        output mc_cancel
    );

    modport slave (
        output mc_reqE,
        output mc_ready,
        input  mc_start,
        input  mc_cancel
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage MIPS core: forwarding, load-use stall, multi-cycle unit
// handshake and exception flush. Optional macro HAZARD_BRANCH_STALL_EN adds a D-stage branch stall.
module hazard_ctrl_mc #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NUM_MC = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              branchD,
    input  logic              balD,
    input  logic              jumpD,
    input  logic              jrD,
    input  logic              flush_exc,
    hazard_ctrl_mc_if.master  mc,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushE,
    output logic              flushM,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic [1:0]        forwardaD,
    output logic [1:0]        forwardbD
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q [NUM_MC];
    logic [1:0]        state_d [NUM_MC];
    logic [NUM_MC-1:0] ch_stall;
    logic [NUM_MC-1:0] start;
    logic [NUM_MC-1:0] cancel;
    logic              mc_stall;
    logic              lwstall;
    logic              br_stall;
    logic              fwd_from_e;

    // Outputs of each channel depend only on its own state; kept apart from next-state so the
    // stallE feedback into DONE does not form a combinational loop through one block.
    always_comb begin
        ch_stall = '0;
        start    = '0;
        cancel   = '0;
        for (int k = 0; k < NUM_MC; k++) begin
            case (state_q[k])
                StIdle: begin
                    start[k]    = mc.mc_reqE[k] & ~flush_exc;
                    ch_stall[k] = mc.mc_reqE[k] & ~flush_exc;
                end
                StRun: begin
                    ch_stall[k] = ~mc.mc_ready[k];
                    cancel[k]   = flush_exc;
                end
                default: ;
            endcase
        end
    end

    assign mc_stall = |ch_stall;
    assign stallE   = mc_stall & ~flush_exc;

    always_comb begin
        for (int k = 0; k < NUM_MC; k++) begin
            state_d[k] = state_q[k];
            if (flush_exc) begin
                state_d[k] = StIdle;
            end else begin
                case (state_q[k])
                    StIdle:  if (mc.mc_reqE[k])  state_d[k] = StRun;
                    StRun:   if (mc.mc_ready[k]) state_d[k] = StDone;
                    StDone:  if (!stallE)        state_d[k] = StIdle;
                    default: state_d[k] = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_MC; k++) state_q[k] <= StIdle;
        end else begin
            for (int k = 0; k < NUM_MC; k++) state_q[k] <= state_d[k];
        end
    end

    assign mc.mc_start  = start;
    assign mc.mc_cancel = cancel;

    assign lwstall = memtoregE & ((rsD == writeregE) | (rtD == writeregE)) & (writeregE != '0);

`ifdef HAZARD_BRANCH_STALL_EN
    // No memtoregM input exists, so track whether the instruction now in M is a load.
    logic load_m_q;
    logic hit_e;
    logic hit_m;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_m_q <= 1'b0;
        end else begin
            load_m_q <= memtoregE & ~stallE & ~flush_exc;
        end
    end

    assign hit_e      = regwriteE & (writeregE != '0) & ((rsD == writeregE) | (rtD == writeregE));
    assign hit_m      = load_m_q & regwriteM & (writeregM != '0)
                      & ((rsD == writeregM) | (rtD == writeregM));
    assign br_stall   = (branchD | jrD) & (hit_e | hit_m);
    assign fwd_from_e = 1'b0;
`else
    logic unused_jr;
    assign unused_jr  = jrD;
    assign br_stall   = 1'b0;
    assign fwd_from_e = regwriteE & ~memtoregE;
`endif

    assign forwardaE = (rsE != '0 && regwriteM && rsE == writeregM) ? 2'b10 :
                       (rsE != '0 && regwriteW && rsE == writeregW) ? 2'b01 : 2'b00;
    assign forwardbE = (rtE != '0 && regwriteM && rtE == writeregM) ? 2'b10 :
                       (rtE != '0 && regwriteW && rtE == writeregW) ? 2'b01 : 2'b00;
    assign forwardaD = (rsD != '0 && fwd_from_e && rsD == writeregE) ? 2'b01 :
                       (rsD != '0 && regwriteM  && rsD == writeregM) ? 2'b10 :
                       (rsD != '0 && regwriteW  && rsD == writeregW) ? 2'b11 : 2'b00;
    assign forwardbD = (rtD != '0 && fwd_from_e && rtD == writeregE) ? 2'b01 :
                       (rtD != '0 && regwriteM  && rtD == writeregM) ? 2'b10 :
                       (rtD != '0 && regwriteW  && rtD == writeregW) ? 2'b11 : 2'b00;

    assign stallF = (lwstall | br_stall | mc_stall) & ~flush_exc;
    assign stallD = stallF;
    // Only the exception flush may clear a stalled E stage.
    assign flushE = flush_exc | (~mc_stall & (lwstall | br_stall | jumpD | (branchD & ~balD)));
    assign flushM = flush_exc;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: directed scenarios plus randomized forwarding and
// multi-cycle handshake traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl_mc;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NUM_MC = 2;

    logic              clk;
    logic              resetn;
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic              regwriteE, regwriteM, regwriteW, memtoregE;
    logic              branchD, balD, jumpD, jrD, flush_exc;
    logic              stallF, stallD, stallE, flushE, flushM;
    logic [1:0]        forwardaE, forwardbE, forwardaD, forwardbD;

    int n_cmp = 0;
    int n_err = 0;

    hazard_ctrl_mc_if #(.NUM_MC(NUM_MC)) mcif ();

    hazard_ctrl_mc #(.REG_AW(REG_AW), .NUM_MC(NUM_MC)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rsD       (rsD),
        .rtD       (rtD),
        .rsE       (rsE),
        .rtE       (rtE),
        .writeregE (writeregE),
        .writeregM (writeregM),
        .writeregW (writeregW),
        .regwriteE (regwriteE),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .memtoregE (memtoregE),
        .branchD   (branchD),
        .balD      (balD),
        .jumpD     (jumpD),
        .jrD       (jrD),
        .flush_exc (flush_exc),
        .mc        (mcif),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .flushE    (flushE),
        .flushM    (flushM),
        .forwardaE (forwardaE),
        .forwardbE (forwardbE),
        .forwardaD (forwardaD),
        .forwardbD (forwardbD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0;
        branchD = 0; balD = 0; jumpD = 0; jrD = 0; flush_exc = 0;
        mcif.mc_reqE = '0;
        mcif.mc_ready = '0;
    endtask

    // One exception-flush cycle returns every channel to idle.
    task automatic clear_and_idle();
        clear_inputs();
        flush_exc = 1;
        tick();
        flush_exc = 0;
    endtask

    // Producers listed youngest first; the first live writer of src supplies the operand.
    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src, input bit d_stage);
        logic [REG_AW-1:0] dst [3];
        bit                live [3];
        logic [1:0]        code [3];
        dst[0] = writeregE; dst[1] = writeregM; dst[2] = writeregW;
`ifdef HAZARD_BRANCH_STALL_EN
        live[0] = 0;
`else
        live[0] = d_stage && regwriteE && !memtoregE;
`endif
        live[1] = regwriteM;
        live[2] = regwriteW;
        code[0] = 2'b01;
        code[1] = 2'b10;
        code[2] = d_stage ? 2'b11 : 2'b01;
        if (src == 0) return 2'b00;
        for (int i = 0; i < 3; i++) if (live[i] && dst[i] == src) return code[i];
        return 2'b00;
    endfunction

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({stallF, stallD, stallE, flushE, flushM, mcif.mc_start, mcif.mc_cancel} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {stallF, stallD, stallE, flushE, flushM,
                     mcif.mc_start, mcif.mc_cancel});
        end
        n_cmp++;
        if ({forwardaE, forwardbE, forwardaD, forwardbD} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_forward: got %b want 0", {forwardaE, forwardbE, forwardaD, forwardbD});
        end
        resetn = 1;
        tick();
    endtask

    task automatic test_forward_directed();
        clear_and_idle();
        regwriteM = 1; writeregM = 0; rsE = 0;
        #1;
        n_cmp++;
        if (forwardaE !== 2'b00) begin
            n_err++; $display("FAIL fwd_zero_reg: got %b want 00", forwardaE);
        end
        rsE = 7; rtE = 7; writeregM = 7; writeregW = 7; regwriteW = 1;
        #1;
        n_cmp++;
        if (forwardaE !== 2'b10) begin
            n_err++; $display("FAIL fwd_m_over_w: got %b want 10", forwardaE);
        end
        regwriteM = 0;
        #1;
        n_cmp++;
        if (forwardbE !== 2'b01) begin
            n_err++; $display("FAIL fwd_w_only: got %b want 01", forwardbE);
        end
        tick();
    endtask

    task automatic test_forward_random();
        logic [7:0] exp_fwd;
        logic [2:0] exp_ctl;
        bit         lw;
        clear_and_idle();
        for (int i = 0; i < 200; i++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1)); memtoregE = 1'($urandom_range(0, 1));
            jumpD = 1'($urandom_range(0, 1)); balD = 1'($urandom_range(0, 1));
`ifdef HAZARD_BRANCH_STALL_EN
            branchD = 0;
`else
            branchD = 1'($urandom_range(0, 1));
`endif
            #1;
            lw = memtoregE && (rsD == writeregE || rtD == writeregE) && writeregE != 0;
            exp_fwd = {ref_fwd(rsE, 0), ref_fwd(rtE, 0), ref_fwd(rsD, 1), ref_fwd(rtD, 1)};
            exp_ctl = {lw, lw, lw || jumpD || (branchD && !balD)};
            n_cmp++;
            if ({forwardaE, forwardbE, forwardaD, forwardbD, stallF, stallD, flushE}
                    !== {exp_fwd, exp_ctl}) begin
                n_err++;
                $display("FAIL fwd_random[%0d]: got %b want %b", i,
                         {forwardaE, forwardbE, forwardaD, forwardbD, stallF, stallD, flushE},
                         {exp_fwd, exp_ctl});
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        clear_and_idle();
        memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8; rtD = 8; rsE = 1; rtE = 2;
        #1;
        n_cmp++;
        if ({stallF, stallD, flushE} !== 3'b111) begin
            n_err++; $display("FAIL load_use_stall: got %b want 111", {stallF, stallD, flushE});
        end
        tick();
        memtoregE = 0; regwriteE = 0; writeregE = 0; rsD = 0; rtD = 0;
        regwriteM = 1; writeregM = 8; rsE = 8; rtE = 8;
        #1;
        n_cmp++;
        if ({forwardaE, forwardbE, stallF} !== 5'b10100) begin
            n_err++;
            $display("FAIL load_use_fwd: got %b want 10100", {forwardaE, forwardbE, stallF});
        end
        tick();
    endtask

    task automatic test_div();
        int stall_cnt = 0;
        int start_cnt = 0;
        clear_and_idle();
        for (int c = 0; c < 37; c++) begin
            mcif.mc_reqE  = (c <= 35) ? 2'b01 : 2'b00;
            mcif.mc_ready = (c == 34 || c == 35) ? 2'b01 : 2'b00;
            #1;
            if (stallE) stall_cnt++;
            if (mcif.mc_start[0]) start_cnt++;
            if (c == 0) begin
                n_cmp++;
                if (mcif.mc_start !== 2'b01) begin
                    n_err++; $display("FAIL div_start: got %b want 01", mcif.mc_start);
                end
            end
            if (c == 34) begin
                n_cmp++;
                if (stallE !== 1'b0) begin
                    n_err++; $display("FAIL div_ready_release: got %b want 0", stallE);
                end
            end
            tick();
        end
        n_cmp++;
        if (stall_cnt != 34) begin
            n_err++; $display("FAIL div_stall_cycles: got %0d want 34", stall_cnt);
        end
        n_cmp++;
        if (start_cnt != 1) begin
            n_err++; $display("FAIL div_start_count: got %0d want 1", start_cnt);
        end
        mcif.mc_reqE = 2'b01;
        mcif.mc_ready = 2'b00;
        #1;
        n_cmp++;
        if (mcif.mc_start !== 2'b01) begin
            n_err++; $display("FAIL div_fresh_start: got %b want 01", mcif.mc_start);
        end
        tick();
        clear_and_idle();
    endtask

    task automatic test_back_to_back();
        int stall_cnt = 0;
        int mul_starts = 0;
        clear_and_idle();
        for (int c = 0; c < 36; c++) begin
            mcif.mc_reqE  = (c <= 34) ? 2'b11 : 2'b00;
            mcif.mc_ready = {c >= 3 && c <= 35, c >= 34 && c <= 35};
            #1;
            if (stallE) stall_cnt++;
            if (mcif.mc_start[1]) mul_starts++;
            if (c == 0) begin
                n_cmp++;
                if (mcif.mc_start !== 2'b11) begin
                    n_err++; $display("FAIL b2b_start: got %b want 11", mcif.mc_start);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (stallE !== 1'b1) begin
                    n_err++; $display("FAIL b2b_div_holds: got %b want 1", stallE);
                end
            end
            tick();
        end
        n_cmp++;
        if (stall_cnt != 34) begin
            n_err++; $display("FAIL b2b_stall_cycles: got %0d want 34", stall_cnt);
        end
        n_cmp++;
        if (mul_starts != 1) begin
            n_err++; $display("FAIL b2b_mul_start_count: got %0d want 1", mul_starts);
        end
        mcif.mc_reqE = 2'b11;
        mcif.mc_ready = 2'b00;
        #1;
        n_cmp++;
        if (mcif.mc_start !== 2'b11) begin
            n_err++; $display("FAIL b2b_fresh_start: got %b want 11", mcif.mc_start);
        end
        tick();
        clear_and_idle();
    endtask

    task automatic test_flush_exc();
        clear_and_idle();
        mcif.mc_reqE = 2'b01;
        repeat (5) tick();
        flush_exc = 1;
        #1;
        n_cmp++;
        if ({mcif.mc_cancel, stallE, flushE, flushM, mcif.mc_start} !== 7'b01_0_1_1_00) begin
            n_err++;
            $display("FAIL flush_cancel: got %b want 0101100",
                     {mcif.mc_cancel, stallE, flushE, flushM, mcif.mc_start});
        end
        tick();
        flush_exc = 0;
        mcif.mc_reqE = 2'b00;
        #1;
        n_cmp++;
        if ({mcif.mc_cancel, stallE} !== 3'b000) begin
            n_err++; $display("FAIL flush_after: got %b want 000", {mcif.mc_cancel, stallE});
        end
        tick();
        mcif.mc_reqE = 2'b01;
        #1;
        n_cmp++;
        if (mcif.mc_start !== 2'b01) begin
            n_err++; $display("FAIL flush_idle_restart: got %b want 01", mcif.mc_start);
        end
        tick();
        clear_and_idle();
    endtask

    task automatic test_mc_random();
        bit         issued [NUM_MC];
        bit         got [NUM_MC];
        logic [1:0] exp_start, exp_cancel, ch;
        bit         any_stall, exp_stall_e;
        logic [7:0] got_v, exp_v;
        clear_and_idle();
        for (int k = 0; k < NUM_MC; k++) begin
            issued[k] = 0; got[k] = 0;
        end
        for (int i = 0; i < 400; i++) begin
            mcif.mc_reqE  = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            mcif.mc_ready = {$urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0};
            flush_exc     = ($urandom_range(0, 24) == 0);
            jumpD         = 1'($urandom_range(0, 1));
            #1;
            for (int k = 0; k < NUM_MC; k++) begin
                exp_start[k]  = !issued[k] && mcif.mc_reqE[k] && !flush_exc;
                ch[k]         = exp_start[k] || (issued[k] && !got[k] && !mcif.mc_ready[k]);
                exp_cancel[k] = flush_exc && issued[k] && !got[k];
            end
            any_stall   = |ch;
            exp_stall_e = any_stall && !flush_exc;
            exp_v = {exp_start, exp_cancel, exp_stall_e, exp_stall_e,
                     flush_exc || (!any_stall && jumpD), flush_exc};
            got_v = {mcif.mc_start, mcif.mc_cancel, stallE, stallF, flushE, flushM};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++; $display("FAIL mc_random[%0d]: got %b want %b", i, got_v, exp_v);
            end
            for (int k = 0; k < NUM_MC; k++) begin
                if (flush_exc) begin
                    issued[k] = 0; got[k] = 0;
                end else if (exp_start[k]) begin
                    issued[k] = 1; got[k] = 0;
                end else if (issued[k] && !got[k] && mcif.mc_ready[k]) begin
                    got[k] = 1;
                end else if (issued[k] && got[k] && !exp_stall_e) begin
                    issued[k] = 0; got[k] = 0;
                end
            end
            tick();
        end
        clear_and_idle();
    endtask

    task automatic test_branch();
        clear_and_idle();
        branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        #1;
`ifdef HAZARD_BRANCH_STALL_EN
        n_cmp++;
        if ({stallF, stallD, flushE, forwardaD} !== 5'b11100) begin
            n_err++;
            $display("FAIL branch_stall: got %b want 11100", {stallF, stallD, flushE, forwardaD});
        end
`else
        n_cmp++;
        if ({stallF, stallD, forwardaD} !== 4'b0001) begin
            n_err++;
            $display("FAIL branch_fwd_e: got %b want 0001", {stallF, stallD, forwardaD});
        end
`endif
        tick();
        regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 3;
        #1;
        n_cmp++;
        if ({stallF, forwardaD} !== 3'b010) begin
            n_err++; $display("FAIL branch_fwd_m: got %b want 010", {stallF, forwardaD});
        end
        tick();
        clear_and_idle();
    endtask

    task automatic test_reset_mid();
        clear_and_idle();
        mcif.mc_reqE = 2'b01;
        tick();
        tick();
        #2;
        resetn = 0;
        #1;
        // Reset drops the channel to idle at once, so the held request shows as a new start.
        n_cmp++;
        if ({mcif.mc_cancel, mcif.mc_start} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_mid: got %b want 0001", {mcif.mc_cancel, mcif.mc_start});
        end
        mcif.mc_reqE = 2'b00;
        tick();
        resetn = 1;
        tick();
    endtask

    initial begin
        clear_inputs();
        resetn = 0;
        test_reset();
        test_forward_directed();
        test_forward_random();
        test_load_use();
        test_div();
        test_back_to_back();
        test_flush_exc();
        test_mc_random();
        test_branch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
